// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM stage.
// One requester is granted at a time. The request is latched into the RAM
// drive registers, and the arbiter waits for ram_ready. It then returns a
// one-cycle ihit/dhit pulse with registered load data. A per-access watchdog
// abandons accesses that never complete and raises a sticky error flag.
module mem_arbiter #(
    parameter int MAX_WAIT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DSERV = 2'd1;
    localparam logic [1:0] ISERV = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]        state_q, state_d;
    logic              ihit_q, ihit_d;
    logic              dhit_q, dhit_d;
    logic [31:0]       iload_q, iload_d;
    logic [31:0]       dload_q, dload_d;
    logic              ramren_q, ramren_d;
    logic              ramwen_q, ramwen_d;
    logic [31:0]       ramaddr_q, ramaddr_d;
    logic [31:0]       ramstore_q, ramstore_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              last_d_q, last_d_d;

    logic d_pend;
    logic grant_d;
    logic grant_i;

    // Arbitration. If both sides are pending, the side that was not served
    // last wins, so neither requester can starve the other.
    always_comb begin
        d_pend  = dREN | dWEN;
        grant_d = d_pend & (~iREN | ~last_d_q);
        grant_i = iREN & (~d_pend | last_d_q);
    end

    // Next-state and next-output logic. Every output is taken from a register.
    always_comb begin
        state_d    = state_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        iload_d    = iload_q;
        dload_d    = dload_q;
        ramren_d   = ramren_q;
        ramwen_d   = ramwen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        err_d      = err_q;
        wait_d     = wait_q;
        last_d_d   = last_d_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d    = DSERV;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    ramwen_d   = dWEN;
                    ramren_d   = dREN & ~dWEN;   // a write wins over a read
                    wait_d     = '0;
                    last_d_d   = 1'b1;
                end else if (grant_i) begin
                    state_d    = ISERV;
                    ramaddr_d  = iaddr;
                    ramwen_d   = 1'b0;
                    ramren_d   = 1'b1;
                    wait_d     = '0;
                    last_d_d   = 1'b0;
                end
            end
            DSERV, ISERV: begin
                if (ram_ready) begin
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    state_d  = RESP;
                    if (state_q == DSERV) begin
                        dhit_d  = 1'b1;
                        dload_d = ramload;
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = ramload;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // The RAM never answered: abandon the access without a hit.
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                // Requests are not sampled during the hit cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            err_q      <= 1'b0;
            wait_q     <= '0;
            last_d_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
            last_d_q   <= last_d_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign err      = err_q;

endmodule
